// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter: round-robin arbiter feeding one registered valid/ready output    |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int NUM_REQ    = 8,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [IDX_W-1:0]              out_idx_o,
  input  logic                          out_ready_i
);

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  can_accept;
  logic                  any_req;
  logic                  grant_en;
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [DATA_WIDTH-1:0] data_sel;

  assign can_accept = !valid_q | out_ready_i;
  assign any_req    = |req_valid_i;
  assign grant_en   = can_accept & any_req;

  // Scan from ptr_q upward with an explicit wrap so non-power-of-two counts work.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int r;
      r = int'(ptr_q) + k;
      if (r >= NUM_REQ) r = r - NUM_REQ;
      if (!found && req_valid_i[r]) begin
        found  = 1'b1;
        winner = IDX_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (winner == IDX_W'(r)) data_sel = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready_o[g] = grant_en & (winner == IDX_W'(g));
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (grant_en) begin
      valid_d = 1'b1;
      data_d  = data_sel;
      idx_d   = winner;
      ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rr_arbiter: directed self-checking bench for 8- and 5-requester arbiters  |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module tb_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [7:0]   v8 = '0;
  logic [255:0] d8;
  logic [7:0]   rdy8;
  logic         ov8;
  logic [31:0]  od8;
  logic [2:0]   oi8;
  logic         ordy8 = 1'b1;

  logic [4:0]   v5 = '0;
  logic [159:0] d5;
  logic [4:0]   rdy5;
  logic         ov5;
  logic [31:0]  od5;
  logic [2:0]   oi5;
  logic         ordy5 = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(8), .DATA_WIDTH(32)) dut8 (
    .clk_i(clk), .arst_i(rst), .req_valid_i(v8), .req_data_i(d8),
    .req_ready_o(rdy8), .out_valid_o(ov8), .out_data_o(od8),
    .out_idx_o(oi8), .out_ready_i(ordy8)
  );

  rr_arbiter #(.NUM_REQ(5), .DATA_WIDTH(32)) dut5 (
    .clk_i(clk), .arst_i(rst), .req_valid_i(v5), .req_data_i(d5),
    .req_ready_o(rdy5), .out_valid_o(ov5), .out_data_o(od5),
    .out_idx_o(oi5), .out_ready_i(ordy5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) d8[r*32 +: 32] = 32'hA5A5_0000 + 32'(r);
    for (int r = 0; r < 5; r++) d5[r*32 +: 32] = 32'h5A5A_0000 + 32'(r);

    // Reset state
    #1;
    chk("rst_valid", 64'(ov8), 64'(0));
    chk("rst_data",  64'(od8), 64'(0));
    chk("rst_idx",   64'(oi8), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single requester
    @(negedge clk);
    v8 = 8'b0000_1000;
    #1;
    chk("single_ready", 64'(rdy8), 64'(8'b0000_1000));
    tick();
    chk("single_valid", 64'(ov8), 64'(1));
    chk("single_data",  64'(od8), 64'(32'hA5A5_0003));
    chk("single_idx",   64'(oi8), 64'(3));
    chk("single_ptr",   64'(dut8.ptr_q), 64'(4));

    // Drain with no new request: data/idx hold, pointer holds while idle
    @(negedge clk);
    v8 = 8'b0;
    tick();
    chk("drain_valid", 64'(ov8), 64'(0));
    chk("drain_data",  64'(od8), 64'(32'hA5A5_0003));
    chk("idle_ptr",    64'(dut8.ptr_q), 64'(4));

    // Wrap priority: move pointer to 6 via requester 5, then request 1 and 5
    @(negedge clk);
    v8 = 8'b0010_0000;
    tick();
    chk("wrap_ptr6", 64'(dut8.ptr_q), 64'(6));
    @(negedge clk);
    v8 = 8'b0010_0010;
    #1;
    chk("wrap_ready1", 64'(rdy8), 64'(8'b0000_0010));
    tick();
    chk("wrap_idx1", 64'(oi8), 64'(1));
    chk("wrap_ptr2", 64'(dut8.ptr_q), 64'(2));
    @(negedge clk);
    v8 = 8'b0010_0000;
    #1;
    chk("wrap_ready5", 64'(rdy8), 64'(8'b0010_0000));
    tick();
    chk("wrap_idx5", 64'(oi8), 64'(5));
    chk("wrap_ptr6b", 64'(dut8.ptr_q), 64'(6));

    // Asynchronous reset mid-cycle while the output register is full
    v8 = 8'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(ov8), 64'(0));
    chk("arst_data",  64'(od8), 64'(0));
    chk("arst_idx",   64'(oi8), 64'(0));
    chk("arst_ptr",   64'(dut8.ptr_q), 64'(0));
    @(negedge clk);
    v8 = 8'hFF;
    tick();
    chk("rst_held_no_accept", 64'(ov8), 64'(0));

    // Full load: 0..7,0,1 with no bubbles
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("full_valid_%0d", i), 64'(ov8), 64'(1));
      chk($sformatf("full_idx_%0d", i),   64'(oi8), 64'(i % 8));
    end
    chk("full_ptr", 64'(dut8.ptr_q), 64'(2));

    // Backpressure: hold idx 2 while 4 and 7 wait
    @(negedge clk);
    v8 = 8'b0000_0100;
    tick();
    chk("bp_load_idx", 64'(oi8), 64'(2));
    @(negedge clk);
    v8 = 8'b1001_0000;
    ordy8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), 64'(rdy8), 64'(0));
      tick();
      chk($sformatf("bp_valid_%0d", i), 64'(ov8), 64'(1));
      chk($sformatf("bp_idx_%0d", i),   64'(oi8), 64'(2));
      chk($sformatf("bp_data_%0d", i),  64'(od8), 64'(32'hA5A5_0002));
      chk($sformatf("bp_ptr_%0d", i),   64'(dut8.ptr_q), 64'(3));
      @(negedge clk);
    end
    ordy8 = 1'b1;
    #1;
    chk("bp_release_ready", 64'(rdy8), 64'(8'b0001_0000));
    tick();
    chk("bp_release_valid", 64'(ov8), 64'(1));
    chk("bp_release_idx",   64'(oi8), 64'(4));
    chk("bp_release_data",  64'(od8), 64'(32'hA5A5_0004));
    @(negedge clk);
    v8 = 8'b1000_0000;
    tick();
    chk("bp_next_idx", 64'(oi8), 64'(7));
    chk("bp_wrap_ptr", 64'(dut8.ptr_q), 64'(0));
    @(negedge clk);
    v8 = 8'b0;
    tick();
    chk("bp_final_drain", 64'(ov8), 64'(0));

    // Non-power-of-two: 5 requesters, sequence 0,1,2,3,4,0
    @(negedge clk);
    v5 = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("np2_valid_%0d", i), 64'(ov5), 64'(1));
      chk($sformatf("np2_idx_%0d", i),   64'(oi5), 64'(i % 5));
      chk($sformatf("np2_data_%0d", i),  64'(od5), 64'(32'h5A5A_0000 + 32'(i % 5)));
    end
    @(negedge clk);
    v5 = 5'b0;
    tick();
    chk("np2_drain", 64'(ov5), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
